reg_file_p: RTL

- Parametrised successor to the 3x8 general-purpose register group: DEPTH registers of WIDTH bits.
- Two independent combinational read ports (s, d) and one write port with an active-low write enable.
- Adds asynchronous reset, an optional hardwired-zero register 0, and optional write-through bypass.
- Adds a sequential clear engine that zeroes the whole file one register per clock, with a busy flag.
- Sits in the datapath feeding the ALU operand buses, same position as the existing register group.

---
 rtl/reg_file_p_if.sv | 25 ++
 rtl/reg_file_p.sv | 131 +++++++++++++
 2 files changed

// File: rtl/reg_file_p_if.sv
// rtl/reg_file_p_if.sv - register file access bus: write port, two read ports, clear request, busy flag
interface reg_file_p_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic             we;
  logic [AW-1:0]    raa;
  logic [AW-1:0]    rba;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] i;
  logic             clr;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] d;
  logic             busy;

  modport master (
    output we, raa, rba, wa, i, clr,
    input  s, d, busy
  );

  modport slave (
    input  we, raa, rba, wa, i, clr,
    output s, d, busy
  );
endinterface

// File: rtl/reg_file_p.sv
// rtl/reg_file_p.sv - DEPTH x WIDTH register file, two combinational read ports, one falling-edge write port
// Optional hardwired-zero R0, optional write-through bypass, and a one-register-per-clock clear sweep.
module reg_file_p #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AW       = 2,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  reg_file_p_if.slave bus
);

  localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LP_LAST  = AW'(DEPTH-1);

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_cnt;
  logic [AW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_busy;
  logic             w_wa_ok;
  logic             w_wa_zero;
  logic             w_wr_ok;
  logic             w_wr_en;
  logic             w_clr_en;
  logic             w_byp;
  logic [WIDTH-1:0] w_byp_data;
  logic [AW-1:0]    w_s_idx;
  logic [AW-1:0]    w_d_idx;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_d;

  assign w_busy    = (r_state == ST_CLEAR);
  assign w_wa_ok   = ({1'b0, bus.wa} < LP_DEPTH);
  assign w_wa_zero = (bus.wa == '0);
  assign w_wr_ok   = !bus.we && w_wa_ok && !(ZERO_REG && w_wa_zero);

  // Out-of-range read addresses alias onto the last implemented register.
  assign w_s_idx = ({1'b0, bus.raa} < LP_DEPTH) ? bus.raa : LP_LAST;
  assign w_d_idx = ({1'b0, bus.rba} < LP_DEPTH) ? bus.rba : LP_LAST;

  assign w_byp      = BYPASS && !w_busy && !bus.we && w_wa_ok;
  assign w_byp_data = (ZERO_REG && w_wa_zero) ? '0 : bus.i;

  always_comb begin
    w_s = r_mem[w_s_idx];
    if (ZERO_REG && (bus.raa == '0)) begin
      w_s = '0;
    end
    if (w_byp && (bus.wa == bus.raa)) begin
      w_s = w_byp_data;
    end
  end

  always_comb begin
    w_d = r_mem[w_d_idx];
    if (ZERO_REG && (bus.rba == '0)) begin
      w_d = '0;
    end
    if (w_byp && (bus.wa == bus.rba)) begin
      w_d = w_byp_data;
    end
  end

  assign bus.s    = w_s;
  assign bus.d    = w_d;
  assign bus.busy = w_busy;

  // A clear request wins over a write presented on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_en     = 1'b0;
    w_clr_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.clr) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end else begin
          w_wr_en = w_wr_ok;
        end
      end
      ST_CLEAR: begin
        w_clr_en = 1'b1;
        if (r_cnt == LP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      if (w_wr_en) begin
        r_mem[bus.wa] <= bus.i;
      end
      if (w_clr_en) begin
        r_mem[r_cnt] <= '0;
      end
    end
  end

endmodule
